a51_wb_macro: RTL and testbench
===============================

Name: a51_wb_macro

Overview:
- Wishbone-slave A5/1 stream-cipher macro for a Caravel-style multi-project user area.
- Software writes a 64-bit key and a 22-bit frame number, then commands an initialisation run and 32-bit keystream generation runs.
- Keystream words are read back over Wishbone and mirrored on the logic analyser.
- When not selected (`active` low), all outputs release to high impedance.

Parameters:
- MPRJ_IO_PADS, 38, compile-time define setting the io_in/io_out/io_oeb width.

Ports:
- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-low; the port keeps the codebase name.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address; only bits [4:2] are decoded.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- la_data_in  in  32  unused.
- la_data_out  out  32  copy of the KEYSTREAM register.
- la_oen  in  32  unused.
- io_in  in  MPRJ_IO_PADS  unused.
- io_out  out  MPRJ_IO_PADS  [0] = current A5/1 output bit, [1] = busy, all other bits 0.
- io_oeb  out  MPRJ_IO_PADS  [1:0] = 0 (driven), all other bits 1.
- active  in  1  1 = drive outputs; 0 = wbs_ack_o, wbs_dat_o, la_data_out, io_out and io_oeb all 'z'.

Behaviour:
- Register map (byte offsets):
  - 0x00 CTRL, write-only, self-clearing. bit0 = INIT, bit1 = GEN; reads return 0.
  - 0x04 STATUS, read-only. bit0 = busy, bit1 = ks_valid.
  - 0x08 KEY_LO = key[31:0].
  - 0x0C KEY_HI = key[63:32].
  - 0x10 FRAME = frame[21:0]; upper bits read 0.
  - 0x14 KEYSTREAM, read-only.
  - 0x18, 0x1C read 0; writes there are ignored.
- Wishbone handshake:
  - wbs_ack_o pulses high for exactly one cycle, in the cycle after stb & cyc is sampled high with ack low.
  - wbs_dat_o is valid while ack is high and 0 otherwise.
  - Every access is acked, including to unmapped addresses.
- Reset (wb_rst_i low, asynchronous):
  - All registers, LFSRs, counters, busy and ks_valid clear to 0.
  - ack = 0; wbs_dat_o = 0.
  - Reset mid-run aborts the run.
- LFSRs:
  - R1 is 19 bits, feedback taps 13, 16, 17, 18; clocking bit R1[8].
  - R2 is 22 bits, feedback taps 20, 21; clocking bit R2[10].
  - R3 is 23 bits, feedback taps 7, 20, 21, 22; clocking bit R3[10].
  - A step shifts left: new bit0 = XOR of taps XOR the input bit.
  - Output bit = R1[18] ^ R2[21] ^ R3[22].
- INIT (accepted only when busy = 0):
  - Clears R1, R2 and R3 and clears ks_valid; busy = 1.
  - Phase K, 64 cycles: all three registers step, injecting key[i] in cycle i, i = 0..63.
  - Phase F, 22 cycles: all three step, injecting frame[j], j = 0..21.
  - Phase W, 100 cycles: majority clocking with input 0; output discarded.
    - Majority clocking: maj = majority of the three clocking bits; a register steps only if its clocking bit equals maj.
  - busy falls after exactly 186 cycles.
- GEN (accepted only when busy = 0):
  - 32 majority-clocked steps; busy = 1 for exactly 32 cycles.
  - Each cycle, KEYSTREAM <= {KEYSTREAM[30:0], out}, where out is the output bit after that step; the first bit generated lands in bit31.
  - At completion ks_valid = 1.
  - GEN without a prior INIT runs on the current LFSR state.
- CTRL writes while busy are ignored; if INIT and GEN are set together, INIT wins.
- KEY/FRAME writes while busy are ignored (still acked).
- A KEYSTREAM read clears ks_valid; a read in the same cycle GEN completes leaves ks_valid = 1.

Test Plan:
- Reset: hold wb_rst_i low mid-run, then release → all registers read 0; STATUS = 0; ack low.
- Handshake: write KEY_LO = 0xDEADBEEF, read back → 0xDEADBEEF; ack exactly one cycle wide per access; read 0x18 → 0.
- Zero vector: key = 0, frame = 0, INIT, poll until busy = 0 (186 cycles), GEN → KEYSTREAM = 0x00000000 after 32 cycles; STATUS = 0x2; read clears to 0x0.
- Reference vector: key = 0x EFCDAB8967452312, frame = 0x134, INIT then 4×GEN → 128 bits match the bit-accurate software A5/1 model with the same bit ordering.
- Busy guard: write KEY_HI and issue GEN during INIT → both ignored; INIT completes at cycle 186 and the result equals the unperturbed run.
- Inactive: active = 0 → all outputs 'z'; active = 1 → io_oeb[1:0] = 0, other io_oeb bits 1; io_out[1] tracks busy.

Source files
------------

// File: rtl/a51_wb_if.sv
// Wishbone slave bus bundle for the A5/1 macro; signal names match the Caravel
// wrapper so the macro drops into the user area unchanged.
interface a51_wb_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/a51_wb_macro.sv
// A5/1 keystream generator behind a Wishbone register file; runs a 186-cycle
// key/frame load and 32-cycle keystream bursts, outputs tri-stated when inactive.
`timescale 1ns/1ps
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module a51_wb_macro (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  a51_wb_if.slave                  wbs,
  input  logic [31:0]              la_data_in,
  output logic [31:0]              la_data_out,
  input  logic [31:0]              la_oen,
  input  logic [`MPRJ_IO_PADS-1:0] io_in,
  output logic [`MPRJ_IO_PADS-1:0] io_out,
  output logic [`MPRJ_IO_PADS-1:0] io_oeb,
  input  logic                     active
);
  localparam int NPADS = `MPRJ_IO_PADS;
  localparam logic [1:0] S_IDLE = 2'd0, S_INIT = 2'd1, S_GEN = 2'd2;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [18:0] r1, r1_nx;
  logic [21:0] r2, r2_nx;
  logic [22:0] r3, r3_nx;
  logic [63:0] key;
  logic [21:0] frame;
  logic [31:0] ks, rdata, dat_q;
  logic        ks_valid, ack_q, busy, acc, wr, rd;
  logic        in_bit, majc, maj, out_nx, cur_out;
  logic [2:0]  adr;

  assign busy    = (state != S_IDLE);
  assign acc     = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
  assign wr      = acc & wbs.wbs_we_i;
  assign rd      = acc & ~wbs.wbs_we_i;
  assign adr     = wbs.wbs_adr_i[4:2];
  assign cur_out = r1[18] ^ r2[21] ^ r3[22];

  wire unused_ok = ^{la_data_in, la_oen, io_in, wbs.wbs_sel_i,
                     wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0]};

  // One LFSR step; during the frame phase cnt is 64..85 so cnt[4:0] is the frame index
  always_comb begin
    in_bit = 1'b0;
    majc   = 1'b0;
    if (state == S_INIT) begin
      if (cnt < 8'd64)      in_bit = key[cnt[5:0]];
      else if (cnt < 8'd86) in_bit = frame[cnt[4:0]];
      else                  majc   = 1'b1;
    end else if (state == S_GEN) begin
      majc = 1'b1;
    end
    maj   = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
    r1_nx = (!majc || r1[8]  == maj) ? {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ in_bit} : r1;
    r2_nx = (!majc || r2[10] == maj) ? {r2[20:0], r2[20] ^ r2[21] ^ in_bit} : r2;
    r3_nx = (!majc || r3[10] == maj) ? {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ in_bit} : r3;
    out_nx = r1_nx[18] ^ r2_nx[21] ^ r3_nx[22];
  end

  always_comb begin
    rdata = '0;
    case (adr)
      3'd1: rdata = {30'd0, ks_valid, busy};
      3'd2: rdata = key[31:0];
      3'd3: rdata = key[63:32];
      3'd4: rdata = {10'd0, frame};
      3'd5: rdata = ks;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state <= S_IDLE; cnt <= '0;
      r1 <= '0; r2 <= '0; r3 <= '0;
      key <= '0; frame <= '0; ks <= '0; ks_valid <= 1'b0;
      ack_q <= 1'b0; dat_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= rd ? rdata : '0;
      if (wr && !busy) begin
        case (adr)
          3'd2: key[31:0]  <= wbs.wbs_dat_i;
          3'd3: key[63:32] <= wbs.wbs_dat_i;
          3'd4: frame      <= wbs.wbs_dat_i[21:0];
          default: ;
        endcase
      end
      if (rd && adr == 3'd5) ks_valid <= 1'b0;
      // Later assignments win, so a completing GEN keeps ks_valid over a same-cycle read
      case (state)
        S_IDLE: begin
          if (wr && adr == 3'd0 && wbs.wbs_dat_i[0]) begin
            r1 <= '0; r2 <= '0; r3 <= '0;
            ks_valid <= 1'b0; cnt <= '0; state <= S_INIT;
          end else if (wr && adr == 3'd0 && wbs.wbs_dat_i[1]) begin
            cnt <= '0; state <= S_GEN;
          end
        end
        S_INIT: begin
          r1 <= r1_nx; r2 <= r2_nx; r3 <= r3_nx;
          cnt <= cnt + 8'd1;
          if (cnt == 8'd185) state <= S_IDLE;
        end
        S_GEN: begin
          r1 <= r1_nx; r2 <= r2_nx; r3 <= r3_nx;
          ks  <= {ks[30:0], out_nx};
          cnt <= cnt + 8'd1;
          if (cnt == 8'd31) begin
            state <= S_IDLE; ks_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wbs.wbs_ack_o = active ? ack_q : 1'bz;
  assign wbs.wbs_dat_o = active ? dat_q : 32'hzzzz_zzzz;
  assign la_data_out   = active ? ks : 32'hzzzz_zzzz;
  assign io_out        = active ? {{(NPADS-2){1'b0}}, busy, cur_out} : {NPADS{1'bz}};
  assign io_oeb        = active ? {{(NPADS-2){1'b1}}, 2'b00} : {NPADS{1'bz}};
endmodule

// File: tb/tb_a51_wb_macro.sv
// Directed bench for a51_wb_macro: register access, run timing, busy guard,
// reset abort, tri-state release and keystream against an independent A5/1 model.
`timescale 1ns/1ps
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module tb_a51_wb_macro;
  localparam int NP = `MPRJ_IO_PADS;

  logic          clk = 1'b0, rst_n = 1'b0, active = 1'b1;
  logic [31:0]   la_data_in = '0, la_oen = '0, la_data_out;
  logic [NP-1:0] io_in = '0, io_out, io_oeb;
  int            n_tests = 0, n_fail = 0;
  int unsigned   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  a51_wb_if wbs();

  a51_wb_macro dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs(wbs),
    .la_data_in(la_data_in), .la_data_out(la_data_out), .la_oen(la_oen),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .active(active)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_off(input logic [63:0] v);
    for (int i = 0; i < 64; i++)
      if (!(v[i] === 1'bz || v[i] === 1'b0)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                         output logic [31:0] rd);
    bit ok = 1'b0;
    @(negedge clk);
    wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1; wbs.wbs_we_i = we;
    wbs.wbs_adr_i = adr;  wbs.wbs_dat_i = wd;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wbs.wbs_ack_o === 1'b1) begin ok = 1'b1; break; end
    end
    rd = wbs.wbs_dat_o;
    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
    if (!ok) chk("ack_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] d;
    wb_xfer(1'b1, adr, wd, d);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] rd);
    wb_xfer(1'b0, adr, 32'd0, rd);
  endtask

  task automatic wait_idle(input int unsigned t0, output int unsigned el);
    for (int i = 0; i < 400; i++) begin
      if (io_out[1] !== 1'b1) break;
      @(negedge clk);
    end
    el = cyc_cnt - t0;
  endtask

  // Reference A5/1: registers as mask-tapped parity shifters
  logic [18:0] m1;
  logic [21:0] m2;
  logic [22:0] m3;

  task automatic m_step(input bit inb, input bit majc);
    bit c1, c2, c3, mj;
    c1 = m1[8]; c2 = m2[10]; c3 = m3[10];
    mj = (int'(c1) + int'(c2) + int'(c3)) >= 2;
    if (!majc || c1 == mj) m1 = {m1[17:0], (^(m1 & 19'h72000)) ^ inb};
    if (!majc || c2 == mj) m2 = {m2[20:0], (^(m2 & 22'h300000)) ^ inb};
    if (!majc || c3 == mj) m3 = {m3[21:0], (^(m3 & 23'h700080)) ^ inb};
  endtask

  task automatic m_init(input logic [63:0] k, input logic [21:0] f);
    m1 = '0; m2 = '0; m3 = '0;
    for (int i = 0; i < 64; i++)  m_step(k[i], 1'b0);
    for (int j = 0; j < 22; j++)  m_step(f[j], 1'b0);
    for (int w = 0; w < 100; w++) m_step(1'b0, 1'b1);
  endtask

  task automatic m_gen(output logic [31:0] wd);
    wd = '0;
    for (int i = 0; i < 32; i++) begin
      m_step(1'b0, 1'b1);
      wd = {wd[30:0], m1[18] ^ m2[21] ^ m3[22]};
    end
  endtask

  localparam logic [63:0] REF_KEY   = 64'hEFCDAB89_67452312;
  localparam logic [21:0] REF_FRAME = 22'h134;

  initial begin
    logic [31:0] d, exp_w;
    int unsigned t0, el;

    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
    wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = '0;  wbs.wbs_dat_i = '0;

    // Reset state
    #12;
    chk("rst_ack", 64'(wbs.wbs_ack_o), 64'd0);
    chk("rst_dat", 64'(wbs.wbs_dat_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    wb_rd(32'h04, d); chk("rst_status", 64'(d), 64'd0);

    // Handshake and register map
    wb_wr(32'h08, 32'hDEADBEEF);
    wb_rd(32'h08, d); chk("key_lo_rb", 64'(d), 64'hDEADBEEF);
    @(negedge clk); chk("ack_one_cycle", 64'(wbs.wbs_ack_o), 64'd0);
    chk("dat_idle_zero", 64'(wbs.wbs_dat_o), 64'd0);
    wb_rd(32'h18, d); chk("rd_0x18", 64'(d), 64'd0);
    wb_wr(32'h1C, 32'h12345678);
    wb_rd(32'h1C, d); chk("rd_0x1c", 64'(d), 64'd0);
    wb_rd(32'h00, d); chk("rd_ctrl", 64'(d), 64'd0);
    wb_wr(32'h10, 32'hFFFFFFFF);
    wb_rd(32'h10, d); chk("frame_mask", 64'(d), 64'h003FFFFF);

    // Reference vector: INIT then four GEN bursts
    wb_wr(32'h08, REF_KEY[31:0]);
    wb_wr(32'h0C, REF_KEY[63:32]);
    wb_wr(32'h10, 32'(REF_FRAME));
    wb_wr(32'h00, 32'h1); t0 = cyc_cnt;
    wait_idle(t0, el); chk("init_cycles", 64'(el), 64'd186);
    m_init(REF_KEY, REF_FRAME);
    for (int g = 0; g < 4; g++) begin
      wb_wr(32'h00, 32'h2); t0 = cyc_cnt;
      wait_idle(t0, el); chk("gen_cycles", 64'(el), 64'd32);
      wb_rd(32'h04, d); chk("status_valid", 64'(d), 64'h2);
      m_gen(exp_w);
      chk("la_mirror", 64'(la_data_out), 64'(exp_w));
      wb_rd(32'h14, d); chk($sformatf("ks_word%0d", g), 64'(d), 64'(exp_w));
    end
    wb_rd(32'h04, d); chk("status_cleared", 64'(d), 64'h0);

    // Busy guard: INIT+GEN together (INIT wins), KEY_HI and GEN during the run ignored
    wb_wr(32'h00, 32'h3); t0 = cyc_cnt;
    wb_wr(32'h0C, 32'h12345678);
    wb_wr(32'h00, 32'h2);
    wait_idle(t0, el); chk("guard_init_cycles", 64'(el), 64'd186);
    wb_rd(32'h0C, d); chk("guard_key_hi", 64'(d), 64'(REF_KEY[63:32]));
    wb_wr(32'h00, 32'h2); t0 = cyc_cnt;
    wait_idle(t0, el);
    m_init(REF_KEY, REF_FRAME); m_gen(exp_w);
    wb_rd(32'h14, d); chk("guard_ks", 64'(d), 64'(exp_w));

    // Inactive: everything released
    active = 1'b0; #1;
    chk("off_ack", 64'(is_off(64'(wbs.wbs_ack_o))), 64'd1);
    chk("off_dat", 64'(is_off(64'(wbs.wbs_dat_o))), 64'd1);
    chk("off_la",  64'(is_off(64'(la_data_out))), 64'd1);
    chk("off_io_out", 64'(is_off(64'(io_out))), 64'd1);
    chk("off_io_oeb", 64'(is_off(64'(io_oeb))), 64'd1);
    active = 1'b1; #1;
    chk("on_io_oeb", 64'(io_oeb), 64'({{(NP-2){1'b1}}, 2'b00}));
    chk("on_io_idle", 64'(io_out[NP-1:1]), 64'd0);

    // Mid-run reset aborts and clears everything
    wb_wr(32'h00, 32'h1);
    chk("io_busy", 64'(io_out[1]), 64'd1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("rst_busy", 64'(io_out[1]), 64'd0);
    chk("rst_ack_mid", 64'(wbs.wbs_ack_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_rd(32'h08, d); chk("rst_key_lo", 64'(d), 64'd0);
    wb_rd(32'h0C, d); chk("rst_key_hi", 64'(d), 64'd0);
    wb_rd(32'h10, d); chk("rst_frame", 64'(d), 64'd0);
    wb_rd(32'h14, d); chk("rst_ks", 64'(d), 64'd0);
    wb_rd(32'h04, d); chk("rst_status2", 64'(d), 64'd0);

    // Zero vector
    wb_wr(32'h00, 32'h1); t0 = cyc_cnt;
    wait_idle(t0, el); chk("zero_init_cycles", 64'(el), 64'd186);
    wb_wr(32'h00, 32'h2); t0 = cyc_cnt;
    wait_idle(t0, el); chk("zero_gen_cycles", 64'(el), 64'd32);
    wb_rd(32'h04, d); chk("zero_status", 64'(d), 64'h2);
    wb_rd(32'h14, d); chk("zero_ks", 64'(d), 64'd0);
    wb_rd(32'h04, d); chk("zero_status_clr", 64'(d), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
